// File: rtl/trigger_bank.sv
// Bank of WIDTH multi-mode (JK/D/T/SR) flip-flops updated on prescaled ticks,
// with a saturating change counter and a sticky SR-illegal flag.
module trigger_bank #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             Err_Clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             Tick,
  output logic [CNT_W-1:0] Chg_Cnt,
  output logic             Err
);

  localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]  q_q, q_d, q_upd;
  logic [CNT_W-1:0]  chg_cnt_q, chg_cnt_d;
  logic              err_q, err_d;
  logic              tick;
  logic              sr_illegal;

  function automatic logic next_bit(input logic [1:0] m, input logic q,
                                    input logic j, input logic k);
    logic r;
    case (m)
      MODE_JK: r = j ? (k ? ~q : 1'b1) : (k ? 1'b0 : q);
      MODE_D:  r = j;
      MODE_T:  r = j ? ~q : q;
      default: r = (j & ~k) ? 1'b1 : ((k & ~j) ? 1'b0 : q);  // SR: 11 holds
    endcase
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      assign q_upd[gi] = next_bit(Mode, q_q[gi], J[gi], K[gi]);
    end
  endgenerate

  assign tick       = En & (pcnt_q == PCNT_MAX);
  assign sr_illegal = (Mode == MODE_SR) & (|(J & K));

  always_comb begin
    pcnt_d    = pcnt_q;
    q_d       = q_q;
    chg_cnt_d = chg_cnt_q;
    err_d     = err_q;
    if (En) begin
      pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + PCNT_ONE;
    end
    if (tick) begin
      q_d = q_upd;
      if ((q_upd != q_q) && (chg_cnt_q != {CNT_W{1'b1}})) begin
        chg_cnt_d = chg_cnt_q + CNT_ONE;
      end
    end
    // A new illegal sample outranks a clear requested on the same edge.
    if (tick && sr_illegal) begin
      err_d = 1'b1;
    end else if (Err_Clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      pcnt_q    <= '0;
      q_q       <= '0;
      chg_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      q_q       <= q_d;
      chg_cnt_q <= chg_cnt_d;
      err_q     <= err_d;
    end
  end

  assign Q       = q_q;
  assign Q_n     = ~q_q;
  assign Tick    = tick;
  assign Chg_Cnt = chg_cnt_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_trigger_bank.sv
// Directed bench for trigger_bank (WIDTH=4, PRESCALE=4, CNT_W=2); inputs are
// driven and outputs sampled on the falling clock edge.
module tb_trigger_bank;

  logic       CLK = 1'b0;
  logic       Clr, En, Err_Clr;
  logic [1:0] Mode;
  logic [3:0] J, K;
  logic [3:0] Q, Q_n;
  logic       Tick, Err;
  logic [1:0] Chg_Cnt;

  int passed = 0;
  int total  = 0;

  trigger_bank #(.WIDTH(4), .PRESCALE(4), .CNT_W(2)) dut (
    .CLK(CLK), .Clr(Clr), .En(En), .Mode(Mode), .J(J), .K(K),
    .Err_Clr(Err_Clr), .Q(Q), .Q_n(Q_n), .Tick(Tick), .Chg_Cnt(Chg_Cnt), .Err(Err)
  );

  always #5 CLK = ~CLK;

  // Leaves the prescaler at 0 on a falling edge.
  task automatic do_reset();
    @(negedge CLK); Clr = 1'b1;
    @(negedge CLK); Clr = 1'b0;
  endtask

  // From pcnt=0: three edges reach the tick cycle, the fourth takes the update.
  task automatic tick_step();
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [3:0] exp_q;
    logic [1:0] exp_c;
    logic       exp_t;
    Clr = 1'b1; En = 1'b1; Mode = 2'b00; J = 4'b1111; K = 4'b0000; Err_Clr = 1'b0;
    repeat (2) @(negedge CLK);
    total++; if (Q !== 4'b0000) $display("FAIL rst_q got %b want 0000", Q); else passed++;
    total++; if (Q_n !== 4'b1111) $display("FAIL rst_qn got %b want 1111", Q_n); else passed++;
    total++; if (Tick !== 1'b0) $display("FAIL rst_tick got %b want 0", Tick); else passed++;
    total++; if (Chg_Cnt !== 2'd0) $display("FAIL rst_cnt got %0d want 0", Chg_Cnt); else passed++;
    total++; if (Err !== 1'b0) $display("FAIL rst_err got %b want 0", Err); else passed++;
    Clr = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      exp_t = ((c % 4) == 3);
      exp_q = (c >= 4) ? 4'b1111 : 4'b0000;
      exp_c = (c >= 4) ? 2'd1 : 2'd0;
      total++; if (Tick !== exp_t) $display("FAIL pre_tick c=%0d got %b want %b", c, Tick, exp_t); else passed++;
      total++; if (Q !== exp_q) $display("FAIL pre_q c=%0d got %b want %b", c, Q, exp_q); else passed++;
      total++; if (Chg_Cnt !== exp_c) $display("FAIL pre_cnt c=%0d got %0d want %0d", c, Chg_Cnt, exp_c); else passed++;
    end
    $display("test_reset done: Q=%b Chg_Cnt=%0d", Q, Chg_Cnt);
  endtask

  task automatic test_jk_toggle();
    logic [3:0] exp_q [3];
    exp_q[0] = 4'b1010; exp_q[1] = 4'b0000; exp_q[2] = 4'b1010;
    do_reset();
    Mode = 2'b00; J = 4'b1010; K = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      tick_step();
      total++; if (Q !== exp_q[t]) $display("FAIL jk_q t=%0d got %b want %b", t, Q, exp_q[t]); else passed++;
    end
    total++; if (Q_n !== 4'b0101) $display("FAIL jk_qn got %b want 0101", Q_n); else passed++;
    total++; if (Chg_Cnt !== 2'd3) $display("FAIL jk_cnt got %0d want 3", Chg_Cnt); else passed++;
    $display("test_jk_toggle done: Q=%b Chg_Cnt=%0d", Q, Chg_Cnt);
  endtask

  task automatic test_mode_switch();
    logic [1:0] m   [3];
    logic [3:0] jv  [3];
    logic [3:0] kv  [3];
    logic [3:0] eq  [3];
    m[0] = 2'b01; jv[0] = 4'b0110; kv[0] = 4'b1111; eq[0] = 4'b0110;
    m[1] = 2'b10; jv[1] = 4'b0011; kv[1] = 4'b1111; eq[1] = 4'b0101;
    m[2] = 2'b11; jv[2] = 4'b1000; kv[2] = 4'b0100; eq[2] = 4'b1001;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      Mode = m[s]; J = jv[s]; K = kv[s];
      tick_step();
      total++; if (Q !== eq[s]) $display("FAIL mode_q s=%0d got %b want %b", s, Q, eq[s]); else passed++;
      total++; if (Err !== 1'b0) $display("FAIL mode_err s=%0d got %b want 0", s, Err); else passed++;
    end
    $display("test_mode_switch done: Q=%b Err=%b", Q, Err);
  endtask

  task automatic test_sr_illegal();
    do_reset();
    Mode = 2'b11; J = 4'b0001; K = 4'b0000;
    tick_step();
    total++; if (Q !== 4'b0001) $display("FAIL sr_set got %b want 0001", Q); else passed++;
    J = 4'b0001; K = 4'b0001;
    tick_step();
    total++; if (Q !== 4'b0001) $display("FAIL sr_ill_q got %b want 0001", Q); else passed++;
    total++; if (Err !== 1'b1) $display("FAIL sr_ill_err got %b want 1", Err); else passed++;
    total++; if (Chg_Cnt !== 2'd1) $display("FAIL sr_ill_cnt got %0d want 1", Chg_Cnt); else passed++;
    // Clear on a non-tick edge (pcnt=0).
    Err_Clr = 1'b1;
    @(negedge CLK); Err_Clr = 1'b0;
    total++; if (Err !== 1'b0) $display("FAIL sr_clr got %b want 0", Err); else passed++;
    // Clear held across the tick edge that sees S=R=1 again: set wins.
    Err_Clr = 1'b1;
    repeat (2) @(negedge CLK);
    total++; if (Tick !== 1'b1) $display("FAIL sr_tick got %b want 1", Tick); else passed++;
    @(negedge CLK);
    total++; if (Err !== 1'b1) $display("FAIL sr_setwins got %b want 1", Err); else passed++;
    @(negedge CLK);
    total++; if (Err !== 1'b0) $display("FAIL sr_clr2 got %b want 0", Err); else passed++;
    Err_Clr = 1'b0;
    // J=K=1 in JK mode toggles and must not flag illegal.
    Mode = 2'b00;
    repeat (3) @(negedge CLK);
    total++; if (Q !== 4'b0000) $display("FAIL jk11_q got %b want 0000", Q); else passed++;
    total++; if (Err !== 1'b0) $display("FAIL jk11_err got %b want 0", Err); else passed++;
    $display("test_sr_illegal done: Q=%b Err=%b", Q, Err);
  endtask

  task automatic test_freeze_sat();
    logic [1:0] exp_c;
    do_reset();
    Mode = 2'b01; J = 4'b1111; K = 4'b0000;
    tick_step();
    total++; if (Q !== 4'b1111) $display("FAIL frz_q0 got %b want 1111", Q); else passed++;
    repeat (3) @(negedge CLK);
    total++; if (Tick !== 1'b1) $display("FAIL frz_tick_pre got %b want 1", Tick); else passed++;
    // Drop En inside the tick cycle: tick vanishes, nothing updates.
    En = 1'b0; J = 4'b0000;
    #1;
    total++; if (Tick !== 1'b0) $display("FAIL frz_tick_drop got %b want 0", Tick); else passed++;
    repeat (10) @(negedge CLK);
    total++; if (Q !== 4'b1111) $display("FAIL frz_q got %b want 1111", Q); else passed++;
    total++; if (Chg_Cnt !== 2'd1) $display("FAIL frz_cnt got %0d want 1", Chg_Cnt); else passed++;
    total++; if (Tick !== 1'b0) $display("FAIL frz_tick got %b want 0", Tick); else passed++;
    En = 1'b1;
    #1;
    total++; if (Tick !== 1'b1) $display("FAIL frz_resume got %b want 1", Tick); else passed++;
    @(negedge CLK);
    total++; if (Q !== 4'b0000) $display("FAIL frz_q1 got %b want 0000", Q); else passed++;
    total++; if (Chg_Cnt !== 2'd2) $display("FAIL frz_cnt1 got %0d want 2", Chg_Cnt); else passed++;
    for (int k = 1; k <= 4; k++) begin
      J = (k % 2 == 1) ? 4'b1111 : 4'b0000;
      tick_step();
      exp_c = 2'd3;
      total++; if (Q !== J) $display("FAIL sat_q k=%0d got %b want %b", k, Q, J); else passed++;
      total++; if (Chg_Cnt !== exp_c) $display("FAIL sat_cnt k=%0d got %0d want %0d", k, Chg_Cnt, exp_c); else passed++;
    end
    $display("test_freeze_sat done: Q=%b Chg_Cnt=%0d", Q, Chg_Cnt);
  endtask

  task automatic test_async_reset();
    logic exp_t;
    do_reset();
    Mode = 2'b01; J = 4'b1111; K = 4'b0000;
    tick_step();
    repeat (2) @(negedge CLK);
    total++; if (Q !== 4'b1111) $display("FAIL arst_pre_q got %b want 1111", Q); else passed++;
    #2 Clr = 1'b1;
    #1;
    total++; if (Q !== 4'b0000) $display("FAIL arst_q got %b want 0000", Q); else passed++;
    total++; if (Q_n !== 4'b1111) $display("FAIL arst_qn got %b want 1111", Q_n); else passed++;
    total++; if (Chg_Cnt !== 2'd0) $display("FAIL arst_cnt got %0d want 0", Chg_Cnt); else passed++;
    total++; if (Tick !== 1'b0) $display("FAIL arst_tick got %b want 0", Tick); else passed++;
    @(negedge CLK); Clr = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      exp_t = (c == 3);
      total++; if (Tick !== exp_t) $display("FAIL arst_tick c=%0d got %b want %b", c, Tick, exp_t); else passed++;
    end
    total++; if (Q !== 4'b1111) $display("FAIL arst_post_q got %b want 1111", Q); else passed++;
    $display("test_async_reset done: Q=%b", Q);
  endtask

  initial begin
    test_reset();
    test_jk_toggle();
    test_mode_switch();
    test_sr_illegal();
    test_freeze_sat();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
